// File: rtl/fb_pkg.sv
// fb_pkg
// Shared definitions for the framebuffer plot sink: screen geometry,
// framebuffer depth and address width, the controller state type and the
// (x,y) -> linear address mapping used by both the write and scan paths.
package fb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
    localparam int ADDR_W   = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } fb_state_t;

    // Row-major address y*160 + x, built from shifts so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                     input logic [6:0] y);
        logic [ADDR_W-1:0] yy;
        yy = {8'd0, y};
        return (yy << 7) + (yy << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/fb_plot_sink_if.sv
// fb_plot_sink_if
// Bundles the plot write bus, the clear/scan handshakes, the scanned pixel
// stream and the status outputs of the framebuffer sink.
//   master : drives vga_x/vga_y/vga_colour/vga_plot, clear, scan_start;
//            observes busy, scan_done, scan_x/scan_y/scan_colour/scan_valid,
//            plot_count, oob_flag
//   slave  : the sink itself (opposite directions)
interface fb_plot_sink_if;

    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear;
    logic        busy;
    logic        scan_start;
    logic        scan_done;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [2:0]  scan_colour;
    logic        scan_valid;
    logic [14:0] plot_count;
    logic        oob_flag;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, clear, scan_start,
        input  busy, scan_done, scan_x, scan_y, scan_colour, scan_valid,
               plot_count, oob_flag
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, clear, scan_start,
        output busy, scan_done, scan_x, scan_y, scan_colour, scan_valid,
               plot_count, oob_flag
    );

endinterface

// File: rtl/fb_ram.sv
// fb_ram
// Simple dual-port framebuffer memory: one write port and one synchronous
// read port with read-before-write behaviour on an address collision.
// Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (data appears one cycle later on rdata)
//   rdata : registered read data
module fb_ram #(
    parameter int DEPTH  = 19200,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports in one clocked block: the read samples the array before the
    // write of the same edge lands, which gives the old-data collision result.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fb_plot_sink.sv
// fb_plot_sink
// Framebuffer sink for the plot bus. Captures in-range plots into a
// 160x120x3 framebuffer, runs a raster scan-out with a start/done handshake
// and a bulk clear engine.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fb_plot_sink_if.slave (plot bus, clear/busy, scan handshake,
//         scanned pixel stream, plot_count, oob_flag)
module fb_plot_sink
    import fb_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           rst,
    fb_plot_sink_if.slave  bus
);

    localparam int                DEPTH     = SCREEN_W * SCREEN_H;
    localparam logic [7:0]        X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [6:0]        Y_LAST    = 7'(SCREEN_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [14:0]       COUNT_MAX = 15'h7fff;

    fb_state_t         state;
    fb_state_t         state_nx;

    logic [7:0]        scan_cx;
    logic [6:0]        scan_cy;
    logic [ADDR_W-1:0] clear_addr;

    logic              scan_active;
    logic              clear_active;
    logic              clear_entry;
    logic              scan_last;
    logic              clear_last;

    logic              plot_in_range;
    logic              plot_ok;
    logic              plot_oob;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [2:0]        ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [2:0]        ram_rdata;

    logic              valid_q;
    logic [7:0]        sx_q;
    logic [6:0]        sy_q;
    logic [14:0]       count_q;
    logic              oob_q;
    logic              scan_done_c;

    assign plot_in_range = (bus.vga_x <= X_LAST) && (bus.vga_y <= Y_LAST);
    // Plots arriving while the clear engine owns the write port are dropped
    // silently: they neither write, count, nor flag out-of-range.
    assign plot_ok       = bus.vga_plot &&  plot_in_range && !clear_active;
    assign plot_oob      = bus.vga_plot && !plot_in_range && !clear_active;

    assign scan_last  = (scan_cx == X_LAST) && (scan_cy == Y_LAST);
    assign clear_last = (clear_addr == ADDR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Scan requests win over clear in IDLE; dropping scan_start aborts a scan.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.scan_start) begin
                    state_nx = SCAN;
                end else if (bus.clear) begin
                    state_nx = CLEAR;
                end
            end
            SCAN: begin
                if (!bus.scan_start) begin
                    state_nx = IDLE;
                end else if (scan_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!bus.scan_start) begin
                    state_nx = IDLE;
                end
            end
            CLEAR: begin
                if (clear_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // scan_done waits until the last pipelined beat has left, so it never
    // overlaps scan_valid.
    always_comb begin
        scan_active  = (state == SCAN);
        clear_active = (state == CLEAR);
        clear_entry  = (state == IDLE) && !bus.scan_start && bus.clear;
        scan_done_c  = (state == DONE) && !valid_q;
    end

    // Counters sit at zero outside their state so every scan/clear starts at
    // address 0; the scan counter also returns to zero after the last pixel
    // so no out-of-range read address is ever presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cx    <= '0;
            scan_cy    <= '0;
            clear_addr <= '0;
        end else begin
            if (!scan_active || scan_last) begin
                scan_cx <= '0;
                scan_cy <= '0;
            end else if (scan_cx == X_LAST) begin
                scan_cx <= '0;
                scan_cy <= scan_cy + 7'd1;
            end else begin
                scan_cx <= scan_cx + 8'd1;
            end

            if (clear_active && !clear_last) begin
                clear_addr <= clear_addr + ADDR_W'(1);
            end else begin
                clear_addr <= '0;
            end
        end
    end

    assign ram_we    = clear_active || plot_ok;
    assign ram_waddr = clear_active ? clear_addr : xy_to_addr(bus.vga_x, bus.vga_y);
    assign ram_wdata = clear_active ? 3'd0 : bus.vga_colour;
    assign ram_raddr = xy_to_addr(scan_cx, scan_cy);

    fb_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (3)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Coordinates ride one stage behind the issued address to line up with
    // the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            valid_q <= scan_active;
            sx_q    <= scan_cx;
            sy_q    <= scan_cy;
        end
    end

    // Entering CLEAR wipes the statistics; plot_count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            oob_q   <= 1'b0;
        end else if (clear_entry) begin
            count_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            if (plot_ok && (count_q != COUNT_MAX)) begin
                count_q <= count_q + 15'd1;
            end
            if (plot_oob) begin
                oob_q <= 1'b1;
            end
        end
    end

    assign bus.busy        = clear_active;
    assign bus.scan_done   = scan_done_c;
    assign bus.scan_valid  = valid_q;
    assign bus.scan_x      = sx_q;
    assign bus.scan_y      = sy_q;
    // RAM output is masked outside valid beats so outputs read zero after reset.
    assign bus.scan_colour = valid_q ? ram_rdata : 3'd0;
    assign bus.plot_count  = count_q;
    assign bus.oob_flag    = oob_q;

endmodule

// File: tb/tb_fb_plot_sink.sv
// tb_fb_plot_sink
// Scenario bench for fb_plot_sink. Keeps a reference framebuffer; each scan
// pushes the expected pixel stream into a queue and pops one entry per
// scan_valid beat.
module tb_fb_plot_sink;
    import fb_pkg::*;

    localparam int W          = 160;
    localparam int H          = 120;
    localparam int N_PIX      = W * H;
    localparam int SCAN_LIMIT = 19300;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    fb_plot_sink_if bus();

    fb_plot_sink #(
        .SCREEN_W (W),
        .SCREEN_H (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] model [N_PIX];
    beat_t      exp_q [$];
    int         exp_count;
    bit         exp_oob;
    int         n_checks;
    int         n_fail;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        @(posedge clk);
        #1;
        bus.vga_x      = x;
        bus.vga_y      = y;
        bus.vga_colour = c;
        bus.vga_plot   = 1'b1;
        @(posedge clk);
        #1;
        bus.vga_plot   = 1'b0;
        if (x < W && y < H) begin
            model[int'(y) * W + int'(x)] = c;
            exp_count++;
        end else begin
            exp_oob = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        bus.clear      = 1'b0;
        bus.scan_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.scan_done !== 1'b0 || bus.scan_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: busy=%b done=%b valid=%b, expected 0 0 0",
                     bus.busy, bus.scan_done, bus.scan_valid);
        end
        n_checks++;
        if (bus.scan_x !== 8'd0 || bus.scan_y !== 7'd0 || bus.scan_colour !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_scan_pixel: x=%0d y=%0d c=%0d, expected 0 0 0",
                     bus.scan_x, bus.scan_y, bus.scan_colour);
        end
        n_checks++;
        if (bus.plot_count !== 15'd0 || bus.oob_flag !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: count=%0d oob=%b, expected 0 0",
                     bus.plot_count, bus.oob_flag);
        end
        exp_count = 0;
        exp_oob   = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        @(posedge clk);
        #1 bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_clear_busy: busy=%b, expected 1", bus.busy);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.scan_done !== 1'b0 || bus.scan_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_abandons_clear: busy=%b done=%b valid=%b, expected 0 0 0",
                     bus.busy, bus.scan_done, bus.scan_valid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_stays_abandoned: busy=%b, expected 0", bus.busy);
        end
    endtask

    // Optionally injects an in-range plot (2,1) and an out-of-range plot
    // (200,0) while the clear engine is running; neither may have any effect.
    task automatic test_clear(input bit plot_during);
        int busy_cycles = 0;
        int first_busy  = -1;
        bit fell        = 1'b0;
        @(posedge clk);
        #1 bus.clear = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        for (int cyc = 0; cyc < SCAN_LIMIT && !fell; cyc++) begin
            if (plot_during && cyc == 100) begin
                bus.vga_x = 8'd2; bus.vga_y = 7'd1; bus.vga_colour = 3'd5; bus.vga_plot = 1'b1;
            end else if (plot_during && cyc == 101) begin
                bus.vga_x = 8'd200; bus.vga_y = 7'd0; bus.vga_colour = 3'd1; bus.vga_plot = 1'b1;
            end else begin
                bus.vga_plot = 1'b0;
            end
            @(negedge clk);
            if (bus.busy) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = cyc;
            end else if (first_busy >= 0) begin
                fell = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.vga_plot = 1'b0;
        for (int i = 0; i < N_PIX; i++) model[i] = 3'd0;
        exp_count = 0;
        exp_oob   = 1'b0;
        n_checks++;
        if (busy_cycles != N_PIX || first_busy != 0) begin
            n_fail++;
            $display("[TB] FAIL clear_busy_window: %0d cycles from offset %0d, expected %0d from 0",
                     busy_cycles, first_busy, N_PIX);
        end
        @(negedge clk);
        n_checks++;
        if (bus.plot_count !== 15'(exp_count) || bus.oob_flag !== exp_oob) begin
            n_fail++;
            $display("[TB] FAIL clear_status: count=%0d oob=%b, expected %0d %b",
                     bus.plot_count, bus.oob_flag, exp_count, exp_oob);
        end
    endtask

    // Runs one scan. abort_after<0 runs to completion, otherwise scan_start is
    // dropped once that many beats have been seen. plot_edge>=0 drives plot
    // (px,py,pc) so that it is sampled on the edge that issues read address
    // plot_edge.
    task automatic do_scan(input string tag, input int abort_after, input int plot_edge,
                           input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        beat_t exp_b;
        beat_t got_b;
        int beats       = 0;
        int extra       = 0;
        int first_valid = -1;
        int last_valid  = -1;
        int first_done  = -1;
        int stop_cyc    = -1;
        bit stop_pending = 1'b0;
        bit finished     = 1'b0;

        exp_q.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back('{x: 8'(x), y: 7'(y), c: model[y * W + x]});
            end
        end
        bus.vga_x      = px;
        bus.vga_y      = py;
        bus.vga_colour = pc;
        @(posedge clk);
        #1 bus.scan_start = 1'b1;
        for (int cyc = 0; cyc < SCAN_LIMIT && !finished; cyc++) begin
            @(posedge clk);
            #1;
            bus.vga_plot = (cyc == plot_edge);
            if (stop_pending) begin
                bus.scan_start = 1'b0;
                stop_cyc       = cyc;
                stop_pending   = 1'b0;
            end
            @(negedge clk);
            if (bus.scan_valid) begin
                beats++;
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                if (stop_cyc >= 0 && cyc > stop_cyc) extra++;
                got_b = '{x: bus.scan_x, y: bus.scan_y, c: bus.scan_colour};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL %s_unexpected_beat: got (%0d,%0d) c=%0d, expected no beat",
                             tag, got_b.x, got_b.y, got_b.c);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        n_fail++;
                        $display("[TB] FAIL %s_beat%0d: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d",
                                 tag, beats - 1, got_b.x, got_b.y, got_b.c, exp_b.x, exp_b.y, exp_b.c);
                    end
                end
            end
            if (bus.scan_done && first_done < 0) first_done = cyc;
            if (stop_cyc < 0 && !stop_pending) begin
                if (abort_after >= 0 ? (beats >= abort_after) : (bus.scan_done === 1'b1))
                    stop_pending = 1'b1;
            end
            if (stop_cyc >= 0 && cyc >= stop_cyc + 3) finished = 1'b1;
        end
        bus.scan_start = 1'b0;
        bus.vga_plot   = 1'b0;

        n_checks++;
        if (first_valid != 1) begin
            n_fail++;
            $display("[TB] FAIL %s_first_beat_offset: got %0d, expected 1", tag, first_valid);
        end
        if (abort_after < 0) begin
            n_checks++;
            if (beats != N_PIX || last_valid != N_PIX) begin
                n_fail++;
                $display("[TB] FAIL %s_beat_window: %0d beats ending at %0d, expected %0d ending at %0d",
                         tag, beats, last_valid, N_PIX, N_PIX);
            end
            n_checks++;
            if (first_done != N_PIX + 1) begin
                n_fail++;
                $display("[TB] FAIL %s_done_offset: got %0d, expected %0d", tag, first_done, N_PIX + 1);
            end
        end else begin
            n_checks++;
            if (extra > 1 || first_done >= 0) begin
                n_fail++;
                $display("[TB] FAIL %s_abort_tail: %0d beats after drop, done_seen=%0d, expected <=1 and no done",
                         tag, extra, first_done >= 0);
            end
        end
        n_checks++;
        if (bus.scan_valid !== 1'b0 || bus.scan_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_back_to_idle: valid=%b done=%b busy=%b, expected 0 0 0",
                     tag, bus.scan_valid, bus.scan_done, bus.busy);
        end
        if (plot_edge >= 0) begin
            model[int'(py) * W + int'(px)] = pc;
            exp_count++;
        end
        exp_q.delete();
    endtask

    task automatic test_single_plot();
        drive_plot(8'd5, 7'd3, 3'd6);
        @(negedge clk);
        n_checks++;
        if (bus.plot_count !== 15'(exp_count)) begin
            n_fail++;
            $display("[TB] FAIL single_plot_count: got %0d, expected %0d", bus.plot_count, exp_count);
        end
    endtask

    task automatic test_out_of_range();
        drive_plot(8'd160, 7'd0, 3'd7);
        drive_plot(8'd0, 7'd120, 3'd7);
        @(negedge clk);
        n_checks++;
        if (bus.oob_flag !== exp_oob || bus.plot_count !== 15'(exp_count)) begin
            n_fail++;
            $display("[TB] FAIL oob_status: oob=%b count=%0d, expected %b %0d",
                     bus.oob_flag, bus.plot_count, exp_oob, exp_count);
        end
    endtask

    task automatic test_collision();
        do_scan("collide_scan", -1, 160, 8'd0, 7'd1, 3'd7);
        @(negedge clk);
        n_checks++;
        if (bus.plot_count !== 15'(exp_count)) begin
            n_fail++;
            $display("[TB] FAIL collide_count: got %0d, expected %0d", bus.plot_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        do_scan("rescan", -1, -1, 8'd0, 7'd0, 3'd0);
    endtask

    task automatic test_abort();
        do_scan("abort", 100, -1, 8'd0, 7'd0, 3'd0);
        do_scan("restart", 5, -1, 8'd0, 7'd0, 3'd0);
    endtask

    task automatic test_dropped_plots();
        test_clear(1'b1);
        do_scan("post_clear", 200, -1, 8'd0, 7'd0, 3'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_reset_mid_clear();
        test_clear(1'b0);
        test_single_plot();
        test_out_of_range();
        test_collision();
        test_back_to_back();
        test_abort();
        test_dropped_plots();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
